// File: rtl/fifo_read_drain.sv
// fifo_read_drain
// Read-side drain engine for a synchronous FIFO (or the read-clock side of an
// async FIFO). Issues rd strobes while data is available and there is room,
// absorbs the FIFO's one-cycle read latency, and re-presents words downstream
// through a 2-entry buffer with a valid/ready handshake. Counts delivered words.
//
// Ports:
//   clk        clock (read clock for async FIFOs)
//   rst_n      asynchronous active-low reset
//   en         drain enable; low stops new rd strobes
//   empty      FIFO empty flag
//   Rdata      FIFO read data, valid the cycle after an accepted rd
//   rd         FIFO read strobe (combinational)
//   out_data   head word of the output buffer
//   out_valid  output buffer non-empty
//   out_ready  downstream accepts out_data this cycle
//   words_out  delivered-word count, wraps
//   busy       read in flight or buffer occupied
module fifo_read_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] Rdata,
  output logic                  rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic                  busy
);

  logic                  inflight;
  logic                  head;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] buf_mem [2];

  logic                  pop;
  logic [1:0]            level;
  logic                  wr_idx;

  always_comb begin
    pop    = (occ != 2'd0) && out_ready;
    // occ + inflight never exceeds 2 and pop implies occ >= 1, so 2 bits suffice
    level  = occ + 2'(inflight) - 2'(pop);
    wr_idx = head ^ occ[0];
    // rst_n gates rd so the FIFO sees no strobe while reset is held
    rd     = rst_n && en && !empty && (level < 2'd2);
  end

  assign out_valid = (occ != 2'd0);
  assign out_data  = buf_mem[head];
  assign busy      = inflight || (occ != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      head      <= 1'b0;
      occ       <= 2'd0;
      words_out <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      inflight <= rd;
      // push lands behind the current contents; with a simultaneous pop the
      // head moves onto the older word, so ordering is preserved
      if (inflight) begin
        buf_mem[wr_idx] <= Rdata;
      end
      if (pop) begin
        head      <= ~head;
        words_out <= words_out + CNT_WIDTH'(1);
      end
      occ <= level;
    end
  end

endmodule

// File: tb/tb_fifo_read_drain.sv
// Testbench for fifo_read_drain: a FIFO model feeds Rdata one cycle after each
// rd, expected words go into a scoreboard queue at load time, and a negedge
// monitor pops and compares on every handshake.
module tb_fifo_read_drain;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       empty;
  logic [7:0] rdata;
  logic       rd;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] words_out;
  logic       busy;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] exp;
  } chk_t;

  chk_t       chk_q [$];
  logic [7:0] sb_q [$];
  logic [7:0] src_q [$];
  int         pop_cycs [$];
  int         rd_cycs [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  fifo_read_drain #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .empty(empty), .Rdata(rdata),
    .rd(rd), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .words_out(words_out), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // monitor: handles queued checks, scoreboard pops and hold-stability checks
  initial begin
    chk_t       c;
    logic [7:0] e;
    logic       stall;
    logic [7:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        n_tests++;
        if (c.got !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h, expected %0h", c.name, c.got, c.exp);
        end
      end
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          n_tests++;
          if (out_valid !== 1'b1 || out_data !== held) begin
            n_fail++;
            $display("FAIL hold: got valid=%0b data=%0h, expected valid=1 data=%0h",
                     out_valid, out_data, held);
          end
        end
        if (out_valid && out_ready) begin
          pop_cycs.push_back(cyc);
          n_tests++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pop: got %0h, expected no word", out_data);
          end else begin
            e = sb_q.pop_front();
            if (out_data !== e) begin
              n_fail++;
              $display("FAIL out_data: got %0h, expected %0h", out_data, e);
            end
          end
        end
        stall = out_valid && !out_ready;
        held  = out_data;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.got  = got;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  // one clock: sample rd before the edge, serve read data just after it
  task automatic tick();
    logic rd_s;
    @(negedge clk);
    rd_s = rd;
    if (rd) begin
      rd_cycs.push_back(cyc);
      check("rd_while_empty", 32'(empty), 32'd0);
    end
    @(posedge clk);
    #1;
    if (rd_s && src_q.size() > 0) rdata = src_q.pop_front();
    empty = (src_q.size() == 0);
  endtask

  task automatic load(input int n, input int start);
    logic [7:0] v;
    for (int k = 0; k < n; k++) begin
      v = 8'(start + k);
      src_q.push_back(v);
      sb_q.push_back(v);
    end
    empty = (src_q.size() == 0);
  endtask

  task automatic drain(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0 && src_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int rb;
    int pb;
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1; rdata = '0; empty = 1'b1;
    #1 rst_n = 1'b0;

    // reset with data available
    load(1, 8'hA5);
    repeat (3) tick();
    check("reset_rd", 32'(rd), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_words", 32'(words_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // single word
    rb = rd_cycs.size(); pb = pop_cycs.size();
    rst_n = 1'b1;
    #1 check("rd_after_release", 32'(rd), 32'd1);
    drain(20);
    check("single_rd_count", 32'(rd_cycs.size() - rb), 32'd1);
    check("single_pop_count", 32'(pop_cycs.size() - pb), 32'd1);
    if (rd_cycs.size() > rb && pop_cycs.size() > pb)
      check("single_latency", 32'(pop_cycs[pb] - rd_cycs[rb]), 32'd2);
    check("single_words", 32'(words_out), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // burst of 8
    rb = rd_cycs.size(); pb = pop_cycs.size();
    load(8, 8'h01);
    drain(40);
    check("burst_rd_count", 32'(rd_cycs.size() - rb), 32'd8);
    check("burst_pop_count", 32'(pop_cycs.size() - pb), 32'd8);
    if (rd_cycs.size() == rb + 8)
      check("burst_rd_span", 32'(rd_cycs[rb + 7] - rd_cycs[rb]), 32'd7);
    if (pop_cycs.size() == pb + 8)
      check("burst_pop_span", 32'(pop_cycs[pb + 7] - pop_cycs[pb]), 32'd7);
    check("burst_words", 32'(words_out), 32'd9);

    // backpressure
    out_ready = 1'b0;
    rb = rd_cycs.size(); pb = pop_cycs.size();
    load(4, 8'h10);
    repeat (6) tick();
    check("bp_rd_count", 32'(rd_cycs.size() - rb), 32'd2);
    check("bp_rd_now", 32'(rd), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_data", 32'(out_data), 32'h10);
    out_ready = 1'b1;
    drain(40);
    check("bp_pop_count", 32'(pop_cycs.size() - pb), 32'd4);
    check("bp_rd_total", 32'(rd_cycs.size() - rb), 32'd4);
    check("bp_words", 32'(words_out), 32'd13);

    // enable dropped right after a strobe
    rb = rd_cycs.size();
    load(4, 8'h20);
    tick();
    en = 1'b0;
    repeat (4) tick();
    check("en_rd_count", 32'(rd_cycs.size() - rb), 32'd1);
    check("en_words", 32'(words_out), 32'd14);
    check("en_busy", 32'(busy), 32'd0);

    // re-enable, then reset mid-burst
    en = 1'b1;
    repeat (3) tick();
    check("pre_reset_words", 32'(words_out), 32'd15);
    rst_n = 1'b0;
    #1;
    check("midrst_rd", 32'(rd), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_words", 32'(words_out), 32'd0);
    sb_q.delete();
    src_q.delete();
    empty = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_words", 32'(words_out), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // counter wrap
    load(65535, 0);
    drain(66000);
    check("wrap_ffff", 32'(words_out), 32'h0000FFFF);
    load(1, 8'h5A);
    drain(20);
    check("wrap_0000", 32'(words_out), 32'h00000000);
    load(1, 8'hC3);
    drain(20);
    check("wrap_0001", 32'(words_out), 32'h00000001);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
